// File: rtl/dma_pkg.sv
// Shared types and helpers for the 8237A channel register file.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int AW     = 16;
  localparam int CW     = 16;

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic {BP_LOW, BP_HIGH} bp_t;

  function automatic addr_t step_addr(input addr_t a, input logic dec);
    return dec ? (a - addr_t'(1)) : (a + addr_t'(1));
  endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// One DMA channel: base/current address and word count, byte-wide programming,
// per-transfer stepping and terminal-count detection. Reload on TC needs DMA_AUTOINIT_EN.
module dma_ch_regs
  import dma_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wrAddr,
  input  logic          i_wrCnt,
  input  logic          i_hiByte,
  input  logic [7:0]    i_data,
  input  logic          i_step,
  input  logic          i_dec,
  input  logic          i_autoinit,
  output logic [AW-1:0] o_currAddr,
  output logic [CW-1:0] o_currCnt,
  output logic          o_tcHit
);

  addr_t r_baseAddr;
  addr_t r_currAddr;
  cnt_t  r_baseCnt;
  cnt_t  r_currCnt;
  logic  w_reload;

  // A count write landing on the same edge as a step suppresses the terminal count.
  assign o_tcHit = i_step && !i_wrCnt && (r_currCnt == '0);

`ifdef DMA_AUTOINIT_EN
  assign w_reload = o_tcHit && i_autoinit;
`else
  logic w_unusedAutoinit;
  assign w_unusedAutoinit = i_autoinit;
  assign w_reload = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baseAddr <= '0;
      r_currAddr <= '0;
    end else if (i_wrAddr) begin
      if (i_hiByte) begin
        r_baseAddr[15:8] <= i_data;
        r_currAddr[15:8] <= i_data;
      end else begin
        r_baseAddr[7:0] <= i_data;
        r_currAddr[7:0] <= i_data;
      end
    end else if (w_reload) begin
      r_currAddr <= r_baseAddr;
    end else if (i_step) begin
      r_currAddr <= step_addr(r_currAddr, i_dec);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baseCnt <= '0;
      r_currCnt <= '0;
    end else if (i_wrCnt) begin
      if (i_hiByte) begin
        r_baseCnt[15:8] <= i_data;
        r_currCnt[15:8] <= i_data;
      end else begin
        r_baseCnt[7:0] <= i_data;
        r_currCnt[7:0] <= i_data;
      end
    end else if (w_reload) begin
      r_currCnt <= r_baseCnt;
    end else if (i_step) begin
      r_currCnt <= r_currCnt - cnt_t'(1);
    end
  end

  assign o_currAddr = r_currAddr;
  assign o_currCnt  = r_currCnt;

endmodule

// File: rtl/dma_addr_count_regs.sv
// 8237A channel register file: byte-pointer FF, strobe edge detection, read mux, TC status.
// Optional auto-initialise reload on terminal count is enabled by defining DMA_AUTOINIT_EN.
module dma_addr_count_regs #(
  parameter int NUM_CH = dma_pkg::NUM_CH,
  parameter int AW     = dma_pkg::AW,
  parameter int CW     = dma_pkg::CW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_wrAddr,
  input  logic [NUM_CH-1:0] i_rdAddr,
  input  logic [NUM_CH-1:0] i_wrCnt,
  input  logic [NUM_CH-1:0] i_rdCnt,
  input  logic              i_clrBp,
  input  logic              i_setBp,
  input  logic              i_mclr,
  input  logic              i_rdStatus,
  input  logic [7:0]        i_dbIn,
  output logic [7:0]        o_dbOut,
  input  logic              i_xferStep,
  input  logic [1:0]        i_xferCh,
  input  logic [NUM_CH-1:0] i_addrDec,
  input  logic [NUM_CH-1:0] i_autoinit,
  output logic [AW-1:0]     o_currAddr,
  output logic              o_tc,
  output logic [NUM_CH-1:0] o_tcStatus
);

  import dma_pkg::*;

  logic [NUM_CH-1:0] w_wrAddr, w_rdAddr, w_wrCnt, w_rdCnt;
  logic              w_clrBp, w_setBp, w_mclr, w_rdStatus, w_step;
  logic [NUM_CH-1:0] r_wrAddrQ, r_rdAddrQ, r_wrCntQ, r_rdCntQ;
  logic              r_clrBpQ, r_setBpQ, r_mclrQ, r_rdStatusQ;
  logic [NUM_CH-1:0] w_wrAddrFall, w_rdAddrFall, w_wrCntFall, w_rdCntFall;
  logic              w_clrBpFall, w_setBpFall, w_mclrFall, w_rdStatusFall, w_access;
  bp_t               r_bp;
  logic [7:0]        r_dbIn;
  logic [AW-1:0]     w_currAddr [NUM_CH];
  logic [CW-1:0]     w_currCnt  [NUM_CH];
  logic [NUM_CH-1:0] w_tcHit;
  logic              r_tc;
  logic [NUM_CH-1:0] r_tcStatus;

  // The decoder drives X while gated, so only a solid 1 counts as an active strobe.
  always_comb begin
    w_wrAddr   = '0;
    w_rdAddr   = '0;
    w_wrCnt    = '0;
    w_rdCnt    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_wrAddr[n] = (i_wrAddr[n] === 1'b1);
      w_rdAddr[n] = (i_rdAddr[n] === 1'b1);
      w_wrCnt[n]  = (i_wrCnt[n]  === 1'b1);
      w_rdCnt[n]  = (i_rdCnt[n]  === 1'b1);
    end
    w_clrBp    = (i_clrBp    === 1'b1);
    w_setBp    = (i_setBp    === 1'b1);
    w_mclr     = (i_mclr     === 1'b1);
    w_rdStatus = (i_rdStatus === 1'b1);
    w_step     = (i_xferStep === 1'b1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrAddrQ   <= '0;
      r_rdAddrQ   <= '0;
      r_wrCntQ    <= '0;
      r_rdCntQ    <= '0;
      r_clrBpQ    <= 1'b0;
      r_setBpQ    <= 1'b0;
      r_mclrQ     <= 1'b0;
      r_rdStatusQ <= 1'b0;
    end else begin
      r_wrAddrQ   <= w_wrAddr;
      r_rdAddrQ   <= w_rdAddr;
      r_wrCntQ    <= w_wrCnt;
      r_rdCntQ    <= w_rdCnt;
      r_clrBpQ    <= w_clrBp;
      r_setBpQ    <= w_setBp;
      r_mclrQ     <= w_mclr;
      r_rdStatusQ <= w_rdStatus;
    end
  end

  assign w_wrAddrFall   = r_wrAddrQ & ~w_wrAddr;
  assign w_rdAddrFall   = r_rdAddrQ & ~w_rdAddr;
  assign w_wrCntFall    = r_wrCntQ  & ~w_wrCnt;
  assign w_rdCntFall    = r_rdCntQ  & ~w_rdCnt;
  assign w_clrBpFall    = r_clrBpQ    & ~w_clrBp;
  assign w_setBpFall    = r_setBpQ    & ~w_setBp;
  assign w_mclrFall     = r_mclrQ     & ~w_mclr;
  assign w_rdStatusFall = r_rdStatusQ & ~w_rdStatus;
  assign w_access = |{w_wrAddrFall, w_rdAddrFall, w_wrCntFall, w_rdCntFall};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bp <= BP_LOW;
    end else if (w_mclrFall || w_clrBpFall) begin
      r_bp <= BP_LOW;
    end else if (w_setBpFall) begin
      r_bp <= BP_HIGH;
    end else if (w_access) begin
      r_bp <= (r_bp == BP_LOW) ? BP_HIGH : BP_LOW;
    end
  end

  // Holding the data while any write strobe is high keeps the value from its last high cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dbIn <= '0;
    end else if (|w_wrAddr || |w_wrCnt) begin
      r_dbIn <= i_dbIn;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    dma_ch_regs u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wrAddr   (w_wrAddrFall[n]),
      .i_wrCnt    (w_wrCntFall[n]),
      .i_hiByte   (r_bp == BP_HIGH),
      .i_data     (r_dbIn),
      .i_step     (w_step && (i_xferCh == 2'(n))),
      .i_dec      (i_addrDec[n]),
      .i_autoinit (i_autoinit[n]),
      .o_currAddr (w_currAddr[n]),
      .o_currCnt  (w_currCnt[n]),
      .o_tcHit    (w_tcHit[n])
    );
  end

  // Later assignments override earlier ones, so the lowest-index address read wins.
  always_comb begin
    o_dbOut = 8'h00;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (w_rdCnt[n]) o_dbOut = (r_bp == BP_HIGH) ? w_currCnt[n][15:8] : w_currCnt[n][7:0];
    end
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (w_rdAddr[n]) o_dbOut = (r_bp == BP_HIGH) ? w_currAddr[n][15:8] : w_currAddr[n][7:0];
    end
    if (i_rst) o_dbOut = 8'h00;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tc       <= 1'b0;
      r_tcStatus <= '0;
    end else begin
      r_tc <= |w_tcHit;
      if (w_mclrFall) r_tcStatus <= '0;
      else            r_tcStatus <= (w_rdStatusFall ? '0 : r_tcStatus) | w_tcHit;
    end
  end

  assign o_currAddr = w_currAddr[i_xferCh];
  assign o_tc       = r_tc;
  assign o_tcStatus = r_tcStatus;

endmodule

// File: tb/tb_dma_addr_count_regs.sv
// Directed testbench for dma_addr_count_regs with hand-computed expectations.
module tb_dma_addr_count_regs;

  localparam int K_WRA = 0, K_WRC = 1, K_RDA = 2, K_RDC = 3;
  localparam int K_CLR = 4, K_SET = 5, K_MCLR = 6, K_RDS = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wrAddr, rdAddr, wrCnt, rdCnt, addrDec, autoinit;
  logic        clrBp, setBp, mclr, rdStatus, xferStep;
  logic [7:0]  dbIn, dbOut;
  logic [1:0]  xferCh;
  logic [15:0] currAddr;
  logic        tc;
  logic [3:0]  tcStatus;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  dma_addr_count_regs dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wrAddr   (wrAddr),
    .i_rdAddr   (rdAddr),
    .i_wrCnt    (wrCnt),
    .i_rdCnt    (rdCnt),
    .i_clrBp    (clrBp),
    .i_setBp    (setBp),
    .i_mclr     (mclr),
    .i_rdStatus (rdStatus),
    .i_dbIn     (dbIn),
    .o_dbOut    (dbOut),
    .i_xferStep (xferStep),
    .i_xferCh   (xferCh),
    .i_addrDec  (addrDec),
    .i_autoinit (autoinit),
    .o_currAddr (currAddr),
    .o_tc       (tc),
    .o_tcStatus (tcStatus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: strobe high for one clock, low for one clock so its action lands.
  task automatic applyStimulus(input int kind, input int ch, input logic [7:0] data,
                               output logic [7:0] obs);
    @(negedge clk);
    dbIn = data;
    case (kind)
      K_WRA:   wrAddr[ch] = 1'b1;
      K_WRC:   wrCnt[ch]  = 1'b1;
      K_RDA:   rdAddr[ch] = 1'b1;
      K_RDC:   rdCnt[ch]  = 1'b1;
      K_CLR:   clrBp      = 1'b1;
      K_SET:   setBp      = 1'b1;
      K_MCLR:  mclr       = 1'b1;
      default: rdStatus   = 1'b1;
    endcase
    #1 obs = dbOut;
    @(negedge clk);
    wrAddr = '0; wrCnt = '0; rdAddr = '0; rdCnt = '0;
    clrBp = 1'b0; setBp = 1'b0; mclr = 1'b0; rdStatus = 1'b0;
    @(negedge clk);
  endtask

  task automatic writeWord(input int kind, input int ch, input logic [15:0] val);
    logic [7:0] d;
    applyStimulus(K_CLR, 0, 8'h00, d);
    applyStimulus(kind, ch, val[7:0], d);
    applyStimulus(kind, ch, val[15:8], d);
  endtask

  task automatic readWord(input int kind, input int ch, output logic [15:0] val);
    logic [7:0] lo, hi, d;
    applyStimulus(K_CLR, 0, 8'h00, d);
    applyStimulus(kind, ch, 8'h00, lo);
    applyStimulus(kind, ch, 8'h00, hi);
    val = {hi, lo};
  endtask

  task automatic stepOnce(input logic [1:0] ch);
    @(negedge clk);
    xferCh   = ch;
    xferStep = 1'b1;
    @(negedge clk);
    xferStep = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  obs;
    logic [15:0] word;
    logic [15:0] expA, expC;

    rst = 1'b1;
    wrAddr = '0; rdAddr = '0; wrCnt = '0; rdCnt = '0; addrDec = '0; autoinit = '0;
    clrBp = 1'b0; setBp = 1'b0; mclr = 1'b0; rdStatus = 1'b0; xferStep = 1'b0;
    dbIn = '0; xferCh = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_dbout", dbOut, 8'h00);
    checkOutput("rst_addr", currAddr, 16'h0000);
    checkOutput("rst_tc", tc, 1'b0);
    checkOutput("rst_tcstat", tcStatus, 4'h0);
    rst = 1'b0;

    // Program channel 0 address low byte then high byte
    applyStimulus(K_CLR, 0, 8'h00, obs);
    applyStimulus(K_WRA, 0, 8'h34, obs);
    applyStimulus(K_WRA, 0, 8'h12, obs);
    checkOutput("wr_addr0", currAddr, 16'h1234);

    applyStimulus(K_RDA, 0, 8'h00, obs);
    checkOutput("rd_addr0_lo", obs, 8'h34);
    applyStimulus(K_RDA, 0, 8'h00, obs);
    checkOutput("rd_addr0_hi", obs, 8'h12);

    writeWord(K_WRC, 0, 16'hCDAB);
    applyStimulus(K_SET, 0, 8'h00, obs);
    applyStimulus(K_RDC, 0, 8'h00, obs);
    checkOutput("setbp_cnt0_hi", obs, 8'hCD);
    applyStimulus(K_RDC, 0, 8'h00, obs);
    checkOutput("setbp_cnt0_lo", obs, 8'hAB);

    // Two reads at once: address read of channel 0 wins
    applyStimulus(K_CLR, 0, 8'h00, obs);
    @(negedge clk);
    rdAddr[0] = 1'b1; rdCnt[0] = 1'b1; rdCnt[1] = 1'b1;
    #1 checkOutput("rd_priority", dbOut, 8'h34);
    @(negedge clk);
    rdAddr = '0; rdCnt = '0;
    @(negedge clk);

    // Channel 1 counts down through terminal count
    writeWord(K_WRC, 1, 16'h0002);
    writeWord(K_WRA, 1, 16'hFFFF);
    xferCh = 2'd1;
    #1 checkOutput("ch1_addr_init", currAddr, 16'hFFFF);
    stepOnce(2'd1);
    checkOutput("step1_addr", currAddr, 16'h0000);
    checkOutput("step1_tc", tc, 1'b0);
    readWord(K_RDC, 1, word);
    checkOutput("step1_cnt", word, 16'h0001);
    stepOnce(2'd1);
    checkOutput("step2_addr", currAddr, 16'h0001);
    checkOutput("step2_tc", tc, 1'b0);
    readWord(K_RDC, 1, word);
    checkOutput("step2_cnt", word, 16'h0000);
    stepOnce(2'd1);
    checkOutput("step3_addr", currAddr, 16'h0002);
    checkOutput("step3_tc", tc, 1'b1);
    checkOutput("step3_tcstat", tcStatus, 4'b0010);
    @(negedge clk);
    checkOutput("step3_tc_drop", tc, 1'b0);
    readWord(K_RDC, 1, word);
    checkOutput("step3_cnt", word, 16'hFFFF);

    // Channel 2 decrements its address across zero
    addrDec[2] = 1'b1;
    writeWord(K_WRC, 2, 16'h0005);
    writeWord(K_WRA, 2, 16'h0000);
    stepOnce(2'd2);
    checkOutput("dec_addr", currAddr, 16'hFFFF);
    checkOutput("dec_tc", tc, 1'b0);
    checkOutput("dec_tcstat", tcStatus, 4'b0010);
    readWord(K_RDC, 2, word);
    checkOutput("dec_cnt", word, 16'h0004);

    // Channel 3 terminal count with auto-initialise requested
`ifdef DMA_AUTOINIT_EN
    expA = 16'h0100; expC = 16'h0000;
`else
    expA = 16'h0101; expC = 16'hFFFF;
`endif
    autoinit[3] = 1'b1;
    writeWord(K_WRC, 3, 16'h0000);
    writeWord(K_WRA, 3, 16'h0100);
    stepOnce(2'd3);
    checkOutput("ai_tc", tc, 1'b1);
    checkOutput("ai_addr", currAddr, expA);
    checkOutput("ai_tcstat", tcStatus, 4'b1010);
    readWord(K_RDC, 3, word);
    checkOutput("ai_cnt", word, expC);

    // Status read-to-clear coinciding with a new TC on channel 1: the set survives
    writeWord(K_WRC, 1, 16'h0000);
    @(negedge clk);
    rdStatus = 1'b1;
    @(negedge clk);
    rdStatus = 1'b0; xferCh = 2'd1; xferStep = 1'b1;
    @(negedge clk);
    xferStep = 1'b0;
    checkOutput("setwins_tcstat", tcStatus, 4'b0010);
    checkOutput("setwins_tc", tc, 1'b1);
    checkOutput("setwins_addr", currAddr, 16'h0003);

    // Master clear drops FF and status but keeps the registers
    applyStimulus(K_SET, 0, 8'h00, obs);
    applyStimulus(K_MCLR, 0, 8'h00, obs);
    checkOutput("mclr_tcstat", tcStatus, 4'h0);
    checkOutput("mclr_addr_kept", currAddr, 16'h0003);
    applyStimulus(K_RDA, 1, 8'h00, obs);
    checkOutput("mclr_ff_low", obs, 8'h03);

    // Count write and step on the same edge: the write wins and no TC
    writeWord(K_WRC, 2, 16'h0000);
    applyStimulus(K_CLR, 0, 8'h00, obs);
    @(negedge clk);
    wrCnt[2] = 1'b1; dbIn = 8'h07;
    @(negedge clk);
    wrCnt = '0; xferCh = 2'd2; xferStep = 1'b1;
    @(negedge clk);
    xferStep = 1'b0;
    checkOutput("wrwins_tc", tc, 1'b0);
    checkOutput("wrwins_tcstat", tcStatus, 4'h0);
    checkOutput("wrwins_addr", currAddr, 16'hFFFE);
    applyStimulus(K_WRC, 2, 8'h00, obs);
    readWord(K_RDC, 2, word);
    checkOutput("wrwins_cnt", word, 16'h0007);

    // Reset asserted in the middle of a step
    xferCh = 2'd1;
    @(negedge clk);
    xferStep = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    xferStep = 1'b0;
    checkOutput("midrst_addr", currAddr, 16'h0000);
    checkOutput("midrst_tc", tc, 1'b0);
    checkOutput("midrst_tcstat", tcStatus, 4'h0);
    checkOutput("midrst_dbout", dbOut, 8'h00);
    rst = 1'b0;
    readWord(K_RDA, 0, word);
    checkOutput("midrst_addr0", word, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
